// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scan_pkg
// Description : Shared scan-ID toggle interface types and default parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } scan_tx_state_t;

    localparam int SCAN_MIN_HOLD = 4;
    localparam int SCAN_PEND_W   = 4;
    localparam int SCAN_CNT_W    = 8;

    // Width of a down-counter that must hold values 0..min_hold.
    function automatic int scan_hold_w(input int min_hold);
        return $clog2(min_hold + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_hold_timer.sv
`default_nettype none
// ============================================================================
// Module      : scan_hold_timer
// Description : Loadable down-counter that keeps scan_id stable between toggles.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_hold_timer
    import scan_pkg::*;
#(
    parameter int MIN_HOLD = SCAN_MIN_HOLD,
    parameter int HOLD_W   = scan_hold_w(MIN_HOLD)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    output logic [HOLD_W-1:0] count,
    output logic              expired
);

    localparam logic [HOLD_W-1:0] c_LOAD_VAL = HOLD_W'(MIN_HOLD - 1);

    logic [HOLD_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= c_LOAD_VAL;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign count   = r_count;
    assign expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/scan_id_toggle_tx.sv
`default_nettype none
// ============================================================================
// Module      : scan_id_toggle_tx
// Description : Queues request pulses and sends each one as a held toggle on scan_id.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_id_toggle_tx
    import scan_pkg::*;
#(
    parameter int MIN_HOLD = SCAN_MIN_HOLD,
    parameter int PEND_W   = SCAN_PEND_W,
    parameter int CNT_W    = SCAN_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              clr,
    output logic              scan_id,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              busy,
    output logic [CNT_W-1:0]  tx_count,
    output logic              ovf
);

    localparam int                c_HOLD_W   = scan_hold_w(MIN_HOLD);
    localparam logic [PEND_W-1:0] c_PEND_MAX = {PEND_W{1'b1}};

    scan_tx_state_t     r_state;
    scan_tx_state_t     w_state_next;
    logic [PEND_W-1:0]  r_pend;
    logic [PEND_W-1:0]  w_pend_next;
    logic               r_scan_id;
    logic [CNT_W-1:0]   r_tx_count;
    logic               r_ovf;
    logic [c_HOLD_W-1:0] w_hold_cnt;
    logic               w_hold_expired;
    logic               w_accept;
    logic               w_toggle;

    assign req_ready = (r_pend != c_PEND_MAX);
    assign w_accept  = req_valid & req_ready;
    // A flush suppresses the toggle so the flushed queue cannot leak one event.
    assign w_toggle  = w_hold_expired & (r_pend != '0) & ~clr;

    scan_hold_timer #(
        .MIN_HOLD (MIN_HOLD),
        .HOLD_W   (c_HOLD_W)
    ) u_hold_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_toggle),
        .count   (w_hold_cnt),
        .expired (w_hold_expired)
    );

    always_comb begin
        w_pend_next = r_pend;
        if (clr) begin
            w_pend_next = {{(PEND_W-1){1'b0}}, w_accept};
        end else begin
            w_pend_next = r_pend + PEND_W'(w_accept) - PEND_W'(w_toggle);
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_toggle) begin
            w_state_next = (MIN_HOLD > 1) ? HOLD : IDLE;
        end else if (w_hold_cnt <= c_HOLD_W'(1)) begin
            w_state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pend     <= '0;
            r_scan_id  <= 1'b0;
            r_tx_count <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pend  <= w_pend_next;
            if (w_toggle) begin
                r_scan_id  <= ~r_scan_id;
                r_tx_count <= r_tx_count + 1'b1;
            end
            if (req_valid & ~req_ready) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign scan_id  = r_scan_id;
    assign pend_cnt = r_pend;
    assign tx_count = r_tx_count;
    assign ovf      = r_ovf;
    assign busy     = (r_pend != '0) | (r_state == HOLD);

endmodule
`default_nettype wire

// File: tb/tb_scan_id_toggle_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_id_toggle_tx
// Description : Randomized bench for scan_id_toggle_tx against a timestamp-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_id_toggle_tx;

    localparam int c_MIN_HOLD = 3;
    localparam int c_PEND_W   = 2;
    localparam int c_CNT_W    = 4;
    localparam int c_PEND_MAX = (1 << c_PEND_W) - 1;

    logic                clk;
    logic                rst_n;
    logic                req_valid;
    logic                req_ready;
    logic                clr;
    logic                scan_id;
    logic [c_PEND_W-1:0] pend_cnt;
    logic                busy;
    logic [c_CNT_W-1:0]  tx_count;
    logic                ovf;

    int n_tests;
    int n_fail;

    // Model state: queue depth, time of last toggle, toggle total, sticky overflow.
    int m_pend;
    int m_edge;
    int m_last_tx;
    int m_tx_total;
    int m_ovf;

    scan_id_toggle_tx #(
        .MIN_HOLD (c_MIN_HOLD),
        .PEND_W   (c_PEND_W),
        .CNT_W    (c_CNT_W)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .clr       (clr),
        .scan_id   (scan_id),
        .pend_cnt  (pend_cnt),
        .busy      (busy),
        .tx_count  (tx_count),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int actual, input int expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_pend     = 0;
        m_edge     = 0;
        m_last_tx  = -1000;
        m_tx_total = 0;
        m_ovf      = 0;
    endtask

    task automatic check_outputs();
        check("scan_id",  int'(scan_id),  m_tx_total % 2);
        check("tx_count", int'(tx_count), m_tx_total % (1 << c_CNT_W));
        check("pend_cnt", int'(pend_cnt), m_pend);
        check("ovf",      int'(ovf),      m_ovf);
        check("busy",     int'(busy),
              int'((m_pend != 0) || (m_edge - m_last_tx <= c_MIN_HOLD - 2)));
        check("req_ready", int'(req_ready), int'(m_pend != c_PEND_MAX));
    endtask

    // One clock: present inputs, advance model by the edge rules, compare after the edge.
    task automatic step(input logic v, input logic c);
        bit ready, accept, tog;
        req_valid = v;
        clr       = c;
        #1;
        ready  = (m_pend != c_PEND_MAX);
        check("req_ready_pre", int'(req_ready), int'(ready));
        accept = v && ready;
        tog    = (m_edge + 1 - m_last_tx >= c_MIN_HOLD) && (m_pend > 0) && !c;
        @(posedge clk);
        m_edge++;
        if (tog) begin
            m_tx_total++;
            m_last_tx = m_edge;
        end
        if (v && !ready) m_ovf = 1;
        m_pend = c ? int'(accept) : m_pend + int'(accept) - int'(tog);
        #1;
        check_outputs();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_scan_id"},   int'(scan_id),   0);
        check({tag, "_pend_cnt"},  int'(pend_cnt),  0);
        check({tag, "_tx_count"},  int'(tx_count),  0);
        check({tag, "_ovf"},       int'(ovf),       0);
        check({tag, "_busy"},      int'(busy),      0);
        check({tag, "_req_ready"}, int'(req_ready), 1);
    endtask

    initial begin
        int first_tx;
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        clr       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;

        // Single request: accepted at edge 1, toggles at edge 2.
        step(1'b1, 1'b0);
        check("single_pend_after_accept", int'(pend_cnt), 1);
        check("single_no_toggle_on_accept", int'(scan_id), 0);
        step(1'b0, 1'b0);
        check("single_toggle", int'(scan_id), 1);
        first_tx = m_last_tx;
        repeat (c_MIN_HOLD + 2) step(1'b0, 1'b0);
        check("single_idle_busy", int'(busy), 0);

        // Held request stream: saturates queue, sets ovf, toggles spaced by MIN_HOLD.
        repeat (8) step(1'b1, 1'b0);
        check("burst_ovf", int'(ovf), 1);
        repeat (3 * c_MIN_HOLD + 3) step(1'b0, 1'b0);

        // Flush while holding with a same-cycle request: one request survives.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("clr_keeps_accept", int'(pend_cnt), 1);
        repeat (c_MIN_HOLD + 3) step(1'b0, 1'b0);

        // Random traffic with occasional flush.
        for (int i = 0; i < 600; i++) begin
            step(1'(($urandom_range(0, 99)) < 55), 1'(($urandom_range(0, 99)) < 6));
        end

        // Asynchronous reset mid-hold with a queue pending.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (c_MIN_HOLD + 3) step(1'b0, 1'b0);
        check("post_rst_no_toggle", int'(tx_count), 0);

        for (int i = 0; i < 400; i++) begin
            step(1'(($urandom_range(0, 99)) < 70), 1'(($urandom_range(0, 99)) < 3));
        end
        check("first_toggle_edge", first_tx, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
